// File: rtl/serial_operand_sender.sv
// serial_operand_sender: accepts an operand pair and emits it
// LSB-first as a vld/a/b/last bit-serial stream.
module serial_operand_sender #(
    parameter  int WIDTH = 8,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    input  logic [LW-1:0]    len,
    input  logic             pause,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    eff_len;
    logic             accept;

    // Zero or oversized lengths fall back to a full-width frame.
    assign eff_len = (len == '0 || len > LW'(WIDTH))
                   ? LW'(WIDTH) : len;

    assign vld    = (state == SEND) && !pause;
    assign a      = vld ? a_sh[0] : 1'b0;
    assign b      = vld ? b_sh[0] : 1'b0;
    assign last   = vld && (cnt == LW'(1));
    assign up_rdy = !rst && ((state == IDLE) || last);
    assign accept = up_vld && up_rdy;

    // Load on accept, shift on each issued beat, hold while paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else if (accept) begin
            state <= SEND;
            cnt   <= eff_len;
            a_sh  <= a_word;
            b_sh  <= b_word;
        end else if (vld) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - LW'(1);
            if (last) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_operand_sender.sv
// tb_serial_operand_sender: directed vectors for the serial
// operand sender, including a bit-serial adder consumer model.
module tb_serial_operand_sender;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_vld = 1'b0;
    logic       up_rdy;
    logic [7:0] a_word = 8'h00;
    logic [7:0] b_word = 8'h00;
    logic [3:0] len = 4'd0;
    logic       pause = 1'b0;
    logic       vld;
    logic       a;
    logic       b;
    logic       last;

    int vecs = 0;
    int errs = 0;

    serial_operand_sender #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .up_vld (up_vld),
        .up_rdy (up_rdy),
        .a_word (a_word),
        .b_word (b_word),
        .len    (len),
        .pause  (pause),
        .vld    (vld),
        .a      (a),
        .b      (b),
        .last   (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input string nm, input int i,
                        input logic ev, input logic ea,
                        input logic eb, input logic el,
                        input logic er);
        #1;
        chk($sformatf("%s b%0d vld", nm, i), 16'(vld), 16'(ev));
        chk($sformatf("%s b%0d a", nm, i), 16'(a), 16'(ea));
        chk($sformatf("%s b%0d b", nm, i), 16'(b), 16'(eb));
        chk($sformatf("%s b%0d last", nm, i), 16'(last), 16'(el));
        chk($sformatf("%s b%0d rdy", nm, i), 16'(up_rdy), 16'(er));
    endtask

    // ea/eb: expected bit of beat i held at index i
    task automatic frame(input string nm,
                         input logic [7:0] aw,
                         input logic [7:0] bw,
                         input logic [3:0] ln, input int nb,
                         input logic [7:0] ea,
                         input logic [7:0] eb);
        up_vld = 1'b1;
        a_word = aw;
        b_word = bw;
        len    = ln;
        #1;
        chk({nm, " acc rdy"}, 16'(up_rdy), 16'd1);
        step();
        up_vld = 1'b0;
        a_word = 8'hFF;
        b_word = 8'hFF;
        for (int i = 0; i < nb; i++) begin
            beat(nm, i + 1, 1'b1, ea[i], eb[i],
                 i == nb - 1, i == nb - 1);
            step();
        end
        beat({nm, " idle"}, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] sum;
    logic        cy;

    initial begin
        #1;
        chk("rst rdy", 16'(up_rdy), 16'd0);
        chk("rst vld", 16'(vld), 16'd0);
        chk("rst last", 16'(last), 16'd0);
        chk("rst a", 16'(a), 16'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post rst rdy", 16'(up_rdy), 16'd1);
        chk("post rst vld", 16'(vld), 16'd0);
        @(negedge clk);

        frame("full", 8'hB5, 8'h3C, 4'd0, 8,
              8'b1011_0101, 8'b0011_1100);
        @(negedge clk);
        frame("len3", 8'h05, 8'h03, 4'd3, 3,
              8'b0000_0101, 8'b0000_0011);
        @(negedge clk);
        frame("len12", 8'hC3, 8'h0F, 4'd12, 8,
              8'b1100_0011, 8'b0000_1111);
        @(negedge clk);

        up_vld = 1'b1;
        a_word = 8'h0A;
        b_word = 8'h06;
        len    = 4'd4;
        step();
        up_vld = 1'b0;
        beat("pause", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        beat("pause", 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        pause = 1'b1;
        beat("pause", 90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        beat("pause", 91, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pause = 1'b0;
        beat("pause", 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        beat("pause", 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        beat("pause idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        up_vld = 1'b1;
        a_word = 8'h03;
        b_word = 8'h01;
        len    = 4'd2;
        step();
        a_word = 8'h02;
        b_word = 8'h03;
        beat("b2b", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        beat("b2b", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        up_vld = 1'b0;
        beat("b2b", 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        beat("b2b", 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        beat("b2b idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        up_vld = 1'b1;
        a_word = 8'hFF;
        b_word = 8'hFF;
        len    = 4'd8;
        step();
        up_vld = 1'b0;
        beat("abort", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        beat("abort", 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        beat("abort", 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        beat("abort rst", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        beat("abort rel", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        beat("abort rel2", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame("after", 8'h05, 8'h03, 4'd3, 3,
              8'b0000_0101, 8'b0000_0011);
        @(negedge clk);

        sum = '0;
        cy  = 1'b0;
        up_vld = 1'b1;
        a_word = 8'h96;
        b_word = 8'h6B;
        len    = 4'd8;
        step();
        a_word = 8'h01;
        b_word = 8'h01;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("add b%0d vld", i), 16'(vld), 16'd1);
            sum[i] = a ^ b ^ cy;
            if (last) cy = 1'b0;
            else      cy = (a & b) | (a & cy) | (b & cy);
            step();
            if (i == 7) up_vld = 1'b0;
        end
        chk("add sum1", {8'h00, sum[7:0]}, 16'h0001);
        chk("add sum2", {8'h00, sum[15:8]}, 16'h0002);
        #1;
        chk("add idle vld", 16'(vld), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule

// File: doc/serial_operand_sender.md
Name: serial_operand_sender

Overview:
Parallel-to-serial transmitter that feeds the team's bit-serial arithmetic blocks. It accepts a pair of WIDTH-bit operands through a valid/ready handshake and emits them LSB-first, one bit per cycle, as the serial stream vld/a/b/last. The downstream serial adder consumes this stream. A pause input lets the consumer or system insert idle cycles (vld low) in the middle of a frame.

Parameters:
WIDTH, 8, operand width in bits; maximum frame length.
LW, $clog2(WIDTH+1), width of the len field (derived; not overridden).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous reset, active-high.
up_vld  input  1  upstream offers an operand pair.
up_rdy  output  1  sender can accept a pair this cycle.
a_word  input  WIDTH  operand A, parallel.
b_word  input  WIDTH  operand B, parallel.
len  input  LW  frame length in bits; 0 or >WIDTH means WIDTH.
pause  input  1  when high, no beat is issued this cycle.
vld  output  1  serial beat valid.
a  output  1  current bit of A (LSB first).
b  output  1  current bit of B (LSB first).
last  output  1  high on the final beat of a frame.

Behaviour:
- States: IDLE, SEND. Registers: a_sh, b_sh (WIDTH), cnt (LW, beats remaining), state.
- Reset (async, on rst high): state=IDLE, cnt=0, a_sh=b_sh=0. While rst is high, up_rdy=0, vld=0, a=0, b=0, last=0.
- Accept: occurs on a posedge with up_vld && up_rdy. It loads a_sh=a_word, b_sh=b_word, and cnt=effective len (0 or >WIDTH gives WIDTH). State becomes SEND. The first beat appears in the cycle after acceptance, so latency from accept to first beat is 1 cycle.
- Outputs, combinational from state and pause:
  - vld = (state==SEND) && !pause.
  - a = vld ? a_sh[0] : 0; b = vld ? b_sh[0] : 0.
  - last = vld && (cnt==1).
- Beat issue: on a posedge where vld=1, shift a_sh and b_sh right by 1 (zero fill) and decrement cnt.
- Pause: on a posedge where pause=1, a_sh, b_sh and cnt hold. The next beat after pause drops carries the same bit that was pending.
- End of frame: on a posedge with last=1, the state returns to IDLE, unless a new accept happens in the same cycle.
- up_rdy = !rst && (state==IDLE || last). The final beat therefore overlaps with acceptance of the next pair, which gives back-to-back frames with no bubble. With pause=1, last=0, so up_rdy stays low in SEND.
- up_rdy does not depend on up_vld. up_vld may depend on up_rdy.
- a_word, b_word and len are sampled only on the accept edge. Changes at other times have no effect.
- Bits above len in a_word/b_word are never emitted.
- Async reset asserted mid-frame aborts the frame. vld and last drop in the same cycle with no further beats, and the partial frame is not resumed.

Test Plan:
- WIDTH=8, len=0, a_word=8'hB5, b_word=8'h3C, pause=0 -> 8 consecutive vld beats starting 1 cycle after accept. a=1,0,1,0,1,1,0,1; b=0,0,1,1,1,1,0,0. last only on beat 8. up_rdy=0 on beats 1-7 and 1 on beat 8.
- len=3, a_word=8'h05, b_word=8'h03 -> 3 beats: a=1,0,1; b=1,1,0. last on beat 3; then state IDLE and vld=0.
- len=4, a_word=8'h0A, b_word=8'h06, pause high for 2 cycles after beat 2 -> vld=1,1,0,0,1,1. a bits 0,1,-,-,0,1 and b bits 0,1,-,-,1,0. During pause a=b=last=0. last on the final beat.
- up_vld held high with two pairs (len=2: 8'h03/8'h01, then 8'h02/8'h03) -> 4 consecutive vld beats with no gap. a=1,1,0,1; b=1,0,1,1. last on beats 2 and 4. Second accept occurs on the beat-2 edge.
- rst pulsed high mid-beat 3 of an 8-beat frame -> vld, last and up_rdy go 0 immediately. After release up_rdy=1, no residual beats, and the next frame starts cleanly.
- Drive the serial adder from this block with a=8'h96, b=8'h6B, len=8 -> collected serial sum bits equal (8'h96+8'h6B)[7:0]=8'h01 LSB-first. Adder carry is cleared after last, verified by an immediate second frame 8'h01+8'h01 giving 8'h02.
